// File: rtl/pattern_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pattern_pkg: shared FSM encoding and default sizes for pattern blocks |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package pattern_pkg;

  localparam int PAT_W_DEF = 8;
  localparam int CNT_W_DEF = 8;
  localparam int GAP_W_DEF = 4;
  localparam int STATE_W   = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/serial_pattern_gen_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | serial_pattern_gen_if: control and serial-output bundle               |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
interface serial_pattern_gen_if
  import pattern_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int GAP_W = GAP_W_DEF
);
  localparam int LEN_W = $clog2(PAT_W) + 1;

  logic             start;
  logic             abort;
  logic [PAT_W-1:0] pattern;
  logic [LEN_W-1:0] len;
  logic [CNT_W-1:0] reps;
  logic [GAP_W-1:0] gap;
  logic             x;
  logic             x_valid;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] rep_cnt;

  modport master (
    output start, abort, pattern, len, reps, gap,
    input  x, x_valid, busy, done, rep_cnt
  );

  modport slave (
    input  start, abort, pattern, len, reps, gap,
    output x, x_valid, busy, done, rep_cnt
  );

endinterface
`default_nettype wire

// File: rtl/pattern_shreg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pattern_shreg: left-aligned loadable shift register + bits-left count |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module pattern_shreg
  import pattern_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF,
  parameter int LEN_W = $clog2(PAT_W) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic             shift,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  output logic             msb,
  output logic             last
);

  logic [PAT_W-1:0] r_sh;
  logic [LEN_W-1:0] r_rem;

  // Left-aligning leaves zeros below the pattern, so once every bit is
  // shifted out the register reads zero and the line idles low by itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh  <= '0;
      r_rem <= '0;
    end else if (clr) begin
      r_sh  <= '0;
      r_rem <= '0;
    end else if (load) begin
      r_sh  <= pattern << (LEN_W'(PAT_W) - len);
      r_rem <= len - LEN_W'(1);
    end else if (shift) begin
      r_sh <= r_sh << 1;
      if (r_rem != '0) r_rem <= r_rem - LEN_W'(1);
    end
  end

  assign msb  = r_sh[PAT_W-1];
  assign last = (r_rem == '0);

endmodule
`default_nettype wire

// File: rtl/serial_pattern_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | serial_pattern_gen: MSB-first repeating pattern transmitter           |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module serial_pattern_gen
  import pattern_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int GAP_W = GAP_W_DEF
) (
  input  logic clk,
  input  logic rst_n,
  serial_pattern_gen_if.slave bus
);

  localparam int LEN_W = $clog2(PAT_W) + 1;

  state_t           r_state, w_state_nxt;
  logic [PAT_W-1:0] r_pat;
  logic [LEN_W-1:0] r_len;
  logic [CNT_W-1:0] r_reps;
  logic [GAP_W-1:0] r_gap;
  logic [GAP_W-1:0] r_gap_cnt;
  logic [CNT_W-1:0] r_rep_cnt;
  logic             r_x_valid, r_busy, r_done;

  logic [LEN_W-1:0] w_len_in;
  logic             w_msb, w_last, w_final;
  logic             w_accept, w_reload, w_load, w_shift, w_clr;
  logic             w_rep_end, w_gap_load, w_done_set;

  always_comb begin
    w_len_in = bus.len;
    if (bus.len == '0 || bus.len > LEN_W'(PAT_W)) w_len_in = LEN_W'(PAT_W);
  end

  assign w_final = (r_reps != '0) && (r_rep_cnt == r_reps - CNT_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (bus.start && !bus.abort) w_state_nxt = ST_SHIFT;
      ST_SHIFT: begin
        if (bus.abort)                 w_state_nxt = ST_IDLE;
        else if (w_last && w_final)    w_state_nxt = ST_IDLE;
        else if (w_last && r_gap != '0) w_state_nxt = ST_GAP;
      end
      ST_GAP: begin
        if (bus.abort)                        w_state_nxt = ST_IDLE;
        else if (r_gap_cnt <= GAP_W'(1))      w_state_nxt = ST_SHIFT;
      end
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_accept   = (r_state == ST_IDLE) && bus.start && !bus.abort;
    w_rep_end  = (r_state == ST_SHIFT) && w_last && !bus.abort;
    w_reload   = (w_rep_end && !w_final && r_gap == '0) ||
                 ((r_state == ST_GAP) && r_gap_cnt <= GAP_W'(1) && !bus.abort);
    w_load     = w_accept || w_reload;
    w_shift    = (r_state == ST_SHIFT) && !bus.abort && !w_reload;
    w_clr      = bus.abort;
    w_gap_load = w_rep_end && !w_final && r_gap != '0;
    w_done_set = w_rep_end && w_final;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pat     <= '0;
      r_len     <= '0;
      r_reps    <= '0;
      r_gap     <= '0;
      r_gap_cnt <= '0;
      r_rep_cnt <= '0;
      r_x_valid <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_pat     <= bus.pattern;
        r_len     <= w_len_in;
        r_reps    <= bus.reps;
        r_gap     <= bus.gap;
        r_rep_cnt <= '0;
      end else if (w_rep_end && r_rep_cnt != '1) begin
        r_rep_cnt <= r_rep_cnt + CNT_W'(1);
      end
      if (w_clr)                                  r_gap_cnt <= '0;
      else if (w_gap_load)                        r_gap_cnt <= r_gap;
      else if (r_state == ST_GAP && r_gap_cnt != '0) r_gap_cnt <= r_gap_cnt - GAP_W'(1);
      r_x_valid <= (w_state_nxt == ST_SHIFT);
      r_busy    <= (w_state_nxt != ST_IDLE);
      r_done    <= w_done_set;
    end
  end

  pattern_shreg #(
    .PAT_W (PAT_W),
    .LEN_W (LEN_W)
  ) u_shreg (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (w_clr),
    .load    (w_load),
    .shift   (w_shift),
    .pattern (w_accept ? bus.pattern : r_pat),
    .len     (w_accept ? w_len_in : r_len),
    .msb     (w_msb),
    .last    (w_last)
  );

  assign bus.x       = w_msb;
  assign bus.x_valid = r_x_valid;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.rep_cnt = r_rep_cnt;

endmodule
`default_nettype wire
